// File: rtl/lc3b_types.sv
// Shared LC-3b types for the L2 upstream interface: word/line typedefs and arbiter enums.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;

   typedef enum logic [1:0] {
      IDLE,
      SERVE_I,
      SERVE_D,
      GAP
   } l2_arb_state_t;

   typedef enum logic {
      GRANT_I,
      GRANT_D
   } l2_arb_grant_t;

endpackage

// File: rtl/l2_arb_latch.sv
// Capture register for the granted transaction: address, op and write-back line.
module l2_arb_latch #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned LINE_W = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              load_wdata,
   input  logic [ADDR_W-1:0] new_address,
   input  logic [LINE_W-1:0] new_wdata,
   input  logic              new_write,
   output logic [ADDR_W-1:0] address,
   output logic [LINE_W-1:0] wdata,
   output logic              write
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         address <= '0;
         wdata   <= '0;
         write   <= 1'b0;
      end else begin
         if (load) begin
            address <= new_address;
            write   <= new_write;
         end
         // wdata only moves on a D-cache grant; I-cache reads leave it alone
         if (load_wdata) begin
            wdata <= new_wdata;
         end
      end
   end

endmodule

// File: rtl/l2_arbiter.sv
// Merges I-cache and D-cache line requests onto the single l2_cache mem port,
// one transaction at a time, returning the response only to the granted side.
module l2_arbiter
   import lc3b_types::*;
#(
   parameter int unsigned ADDR_W      = $bits(lc3b_word),
   parameter int unsigned LINE_W      = $bits(lc3b_line),
   parameter bit          ROUND_ROBIN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic              i_resp,
   output logic [LINE_W-1:0] i_rdata,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_resp,
   output logic [LINE_W-1:0] d_rdata,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_address,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic              l2_resp,
   input  logic [LINE_W-1:0] l2_rdata
);

   l2_arb_state_t state, next_state;
   l2_arb_grant_t last_grant, next_grant;

   logic i_req, d_req;
   logic grant, grant_d;
   logic serving, op_write;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last_grant <= GRANT_I;
      end else begin
         state      <= next_state;
         last_grant <= next_grant;
      end
   end

   always_comb begin
      next_state = state;
      next_grant = last_grant;
      grant      = 1'b0;
      grant_d    = 1'b0;
      case (state)
         IDLE: begin
            if (i_req || d_req) begin
               grant = 1'b1;
               if (i_req && d_req) begin
                  grant_d = ROUND_ROBIN ? (last_grant == GRANT_I) : 1'b1;
               end else begin
                  grant_d = d_req;
               end
               next_state = grant_d ? SERVE_D : SERVE_I;
               next_grant = grant_d ? GRANT_D : GRANT_I;
            end
         end
         SERVE_I, SERVE_D: begin
            if (l2_resp) begin
               next_state = GAP;
            end
         end
         GAP:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Write beats read when a D-cache request illegally raises both.
   l2_arb_latch #(
      .ADDR_W (ADDR_W),
      .LINE_W (LINE_W)
   ) u_latch (
      .clk         (clk),
      .reset       (reset),
      .load        (grant),
      .load_wdata  (grant & grant_d),
      .new_address (grant_d ? d_address : i_address),
      .new_wdata   (d_wdata),
      .new_write   (grant_d & d_write),
      .address     (l2_address),
      .wdata       (l2_wdata),
      .write       (op_write)
   );

   assign serving  = (state == SERVE_I) || (state == SERVE_D);
   assign l2_read  = serving & ~op_write;
   assign l2_write = serving & op_write;

   assign i_resp  = (state == SERVE_I) & l2_resp;
   assign d_resp  = (state == SERVE_D) & l2_resp;
   assign i_rdata = i_resp ? l2_rdata : '0;
   assign d_rdata = d_resp ? l2_rdata : '0;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: a round-robin and a D-priority instance, directed scenarios then random traffic.
module tb_l2_arbiter;

   logic clk = 1'b0;
   logic reset;

   logic         i_read    [2];
   logic [15:0]  i_address [2];
   logic         i_resp    [2];
   logic [127:0] i_rdata   [2];
   logic         d_read    [2];
   logic         d_write   [2];
   logic [15:0]  d_address [2];
   logic [127:0] d_wdata   [2];
   logic         d_resp    [2];
   logic [127:0] d_rdata   [2];
   logic         l2_read   [2];
   logic         l2_write  [2];
   logic [15:0]  l2_address[2];
   logic [127:0] l2_wdata  [2];
   logic         l2_resp   [2];
   logic [127:0] l2_rdata  [2];

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the L2 port, whether the mandatory idle gap is pending,
   // who wins the next tie, and the captured transaction.
   int           owner   [2];   // 0 none, 1 I-cache, 2 D-cache
   bit           blocked [2];
   bit           pref_d  [2];
   logic [15:0]  m_addr  [2];
   logic [127:0] m_wdata [2];
   bit           m_write [2];
   bit           rr      [2];
   bit           i_done  [2];
   bit           d_done  [2];

   always #5 clk = ~clk;

   l2_arbiter #(.ADDR_W(16), .LINE_W(128), .ROUND_ROBIN(1'b1)) dut_rr (
      .clk(clk), .reset(reset),
      .i_read(i_read[0]), .i_address(i_address[0]), .i_resp(i_resp[0]), .i_rdata(i_rdata[0]),
      .d_read(d_read[0]), .d_write(d_write[0]), .d_address(d_address[0]), .d_wdata(d_wdata[0]),
      .d_resp(d_resp[0]), .d_rdata(d_rdata[0]),
      .l2_read(l2_read[0]), .l2_write(l2_write[0]), .l2_address(l2_address[0]),
      .l2_wdata(l2_wdata[0]), .l2_resp(l2_resp[0]), .l2_rdata(l2_rdata[0])
   );

   l2_arbiter #(.ADDR_W(16), .LINE_W(128), .ROUND_ROBIN(1'b0)) dut_dp (
      .clk(clk), .reset(reset),
      .i_read(i_read[1]), .i_address(i_address[1]), .i_resp(i_resp[1]), .i_rdata(i_rdata[1]),
      .d_read(d_read[1]), .d_write(d_write[1]), .d_address(d_address[1]), .d_wdata(d_wdata[1]),
      .d_resp(d_resp[1]), .d_rdata(d_rdata[1]),
      .l2_read(l2_read[1]), .l2_write(l2_write[1]), .l2_address(l2_address[1]),
      .l2_wdata(l2_wdata[1]), .l2_resp(l2_resp[1]), .l2_rdata(l2_rdata[1])
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         owner[k]   = 0;
         blocked[k] = 1'b0;
         pref_d[k]  = 1'b1;
         m_addr[k]  = '0;
         m_wdata[k] = '0;
         m_write[k] = 1'b0;
      end
   endtask

   // Called at a falling edge with inputs already driven: check, advance model, wait a cycle.
   task automatic step();
      bit ir, dr, gd;
      bit e_rd, e_wr, e_ir, e_dr;
      #1;
      if (!reset) model_reset();
      for (int k = 0; k < 2; k++) begin
         e_rd = (owner[k] != 0) && !m_write[k];
         e_wr = (owner[k] != 0) && m_write[k];
         e_ir = (owner[k] == 1) && l2_resp[k];
         e_dr = (owner[k] == 2) && l2_resp[k];
         chk($sformatf("l2_read[%0d]", k),    l2_read[k],    e_rd);
         chk($sformatf("l2_write[%0d]", k),   l2_write[k],   e_wr);
         chk($sformatf("l2_address[%0d]", k), l2_address[k], m_addr[k]);
         chk($sformatf("l2_wdata[%0d]", k),   l2_wdata[k],   m_wdata[k]);
         chk($sformatf("i_resp[%0d]", k),     i_resp[k],     e_ir);
         chk($sformatf("d_resp[%0d]", k),     d_resp[k],     e_dr);
         chk($sformatf("i_rdata[%0d]", k),    i_rdata[k],    e_ir ? l2_rdata[k] : 128'h0);
         chk($sformatf("d_rdata[%0d]", k),    d_rdata[k],    e_dr ? l2_rdata[k] : 128'h0);
         if (e_ir) i_done[k] = 1'b1;
         if (e_dr) d_done[k] = 1'b1;
         if (!reset) begin
            // held in reset
         end else if (owner[k] != 0) begin
            if (l2_resp[k]) begin
               owner[k]   = 0;
               blocked[k] = 1'b1;
            end
         end else if (blocked[k]) begin
            blocked[k] = 1'b0;
         end else begin
            ir = i_read[k];
            dr = d_read[k] | d_write[k];
            if (ir || dr) begin
               gd         = (ir && dr) ? (rr[k] ? pref_d[k] : 1'b1) : dr;
               owner[k]   = gd ? 2 : 1;
               pref_d[k]  = !gd;
               m_addr[k]  = gd ? d_address[k] : i_address[k];
               m_write[k] = gd && d_write[k];
               if (gd) m_wdata[k] = d_wdata[k];
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      for (int k = 0; k < 2; k++) begin
         i_read[k] = 1'b0; i_address[k] = '0;
         d_read[k] = 1'b0; d_write[k] = 1'b0; d_address[k] = '0; d_wdata[k] = '0;
         l2_resp[k] = 1'b0; l2_rdata[k] = '0;
      end
   endtask

   initial begin
      logic [127:0] a5, dead, beef;
      bit exp_d_first [2][3];
      a5   = {16{8'hA5}};
      dead = {4{32'hDEADBEEF}};
      beef = {4{32'h0BADF00D}};
      rr[0] = 1'b1;
      rr[1] = 1'b0;
      model_reset();
      idle_inputs();
      for (int k = 0; k < 2; k++) begin
         i_done[k] = 1'b0; d_done[k] = 1'b0;
      end
      reset = 1'b0;
      @(negedge clk);
      step();
      step();
      reset = 1'b1;
      step();

      // I-cache read, l2 answers on the third serving cycle
      for (int k = 0; k < 2; k++) begin i_read[k] = 1'b1; i_address[k] = 16'h1230; end
      step();
      #1 chk("t1_l2_read", l2_read[0], 1'b1);
      chk("t1_l2_address", l2_address[0], 16'h1230);
      step();
      step();
      for (int k = 0; k < 2; k++) begin l2_resp[k] = 1'b1; l2_rdata[k] = a5; end
      #1 chk("t1_i_resp", i_resp[0], 1'b1);
      chk("t1_i_rdata", i_rdata[0], a5);
      chk("t1_d_resp", d_resp[0], 1'b0);
      step();
      for (int k = 0; k < 2; k++) begin i_read[k] = 1'b0; l2_resp[k] = 1'b0; end
      step();
      step();

      // D-cache write-back; wdata changes mid-service
      for (int k = 0; k < 2; k++) begin
         d_write[k] = 1'b1; d_address[k] = 16'h4440; d_wdata[k] = dead;
      end
      step();
      #1 chk("t2_l2_write", l2_write[0], 1'b1);
      chk("t2_l2_wdata", l2_wdata[0], dead);
      for (int k = 0; k < 2; k++) d_wdata[k] = beef;
      step();
      chk("t2_wdata_held", l2_wdata[0], dead);
      for (int k = 0; k < 2; k++) l2_resp[k] = 1'b1;
      #1 chk("t2_d_resp", d_resp[0], 1'b1);
      step();
      for (int k = 0; k < 2; k++) begin d_write[k] = 1'b0; l2_resp[k] = 1'b0; end
      #1 chk("t2_d_resp_once", d_resp[0], 1'b0);
      step();
      step();

      // Persistent tie after reset: RR gives D,I,D; D-priority gives D,D,D
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
      exp_d_first[0] = '{1'b1, 1'b0, 1'b1};
      exp_d_first[1] = '{1'b1, 1'b1, 1'b1};
      for (int k = 0; k < 2; k++) begin
         i_read[k] = 1'b1; i_address[k] = 16'h2000;
         d_read[k] = 1'b1; d_address[k] = 16'h3000;
      end
      for (int t = 0; t < 3; t++) begin
         step();
         for (int k = 0; k < 2; k++) l2_resp[k] = 1'b1;
         #1;
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("t3_d_resp[%0d]#%0d", k, t), d_resp[k], exp_d_first[k][t]);
            chk($sformatf("t3_i_resp[%0d]#%0d", k, t), i_resp[k], !exp_d_first[k][t]);
         end
         step();
         for (int k = 0; k < 2; k++) l2_resp[k] = 1'b0;
         #1;
         for (int k = 0; k < 2; k++) chk($sformatf("t3_gap_read[%0d]", k), l2_read[k], 1'b0);
         step();
      end
      idle_inputs();
      step();
      step();

      // Async reset during a D read, then a stray l2_resp
      for (int k = 0; k < 2; k++) begin d_read[k] = 1'b1; d_address[k] = 16'h5550; end
      step();
      step();
      reset = 1'b0;
      #1 chk("t5_l2_read_drop", l2_read[0], 1'b0);
      step();
      for (int k = 0; k < 2; k++) begin d_read[k] = 1'b0; l2_resp[k] = 1'b1; end
      reset = 1'b1;
      step();
      #1 chk("t5_stray_d_resp", d_resp[0], 1'b0);
      step();
      for (int k = 0; k < 2; k++) l2_resp[k] = 1'b0;

      // Read and write together: write wins; l2_resp outside service ignored
      for (int k = 0; k < 2; k++) begin
         d_read[k] = 1'b1; d_write[k] = 1'b1; d_address[k] = 16'h6660; d_wdata[k] = dead;
      end
      step();
      #1 chk("t6_l2_write", l2_write[0], 1'b1);
      chk("t6_l2_read", l2_read[0], 1'b0);
      for (int k = 0; k < 2; k++) l2_resp[k] = 1'b1;
      step();
      for (int k = 0; k < 2; k++) begin d_read[k] = 1'b0; d_write[k] = 1'b0; end
      step();
      step();
      step();
      for (int k = 0; k < 2; k++) l2_resp[k] = 1'b0;
      step();

      // Random traffic: requesters hold until their response, l2 answers at random
      for (int k = 0; k < 2; k++) begin i_done[k] = 1'b0; d_done[k] = 1'b0; end
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 2; k++) begin
            int op;
            if (i_done[k]) begin
               i_read[k] = 1'b0; i_done[k] = 1'b0;
            end else if (!i_read[k] && $urandom_range(0, 2) == 0) begin
               i_read[k] = 1'b1; i_address[k] = 16'($urandom) & 16'hFFF0;
            end
            if (d_done[k]) begin
               d_read[k] = 1'b0; d_write[k] = 1'b0; d_done[k] = 1'b0;
            end else if (!d_read[k] && !d_write[k] && $urandom_range(0, 2) == 0) begin
               op = int'($urandom_range(0, 9));
               d_read[k]    = (op < 5) || (op == 9);
               d_write[k]   = (op >= 5);
               d_address[k] = 16'($urandom) & 16'hFFF0;
            end
            d_wdata[k]  = {$urandom, $urandom, $urandom, $urandom};
            l2_resp[k]  = ($urandom_range(0, 2) == 0);
            l2_rdata[k] = {$urandom, $urandom, $urandom, $urandom};
         end
         if (c == 1500) reset = 1'b0;
         if (c == 1502) reset = 1'b1;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
